// File: rtl/microwire_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// microwire_seq_ctrl_pkg
// Shared types for the Microwire EEPROM sequencer: the host operation enum,
// the controller state enum and the 2-bit on-wire opcodes.
// ---------------------------------------------------------------------------
package microwire_seq_ctrl_pkg;

  // Host-side operation encoding, as presented on the op port.
  typedef enum logic [1:0] {
    OP_EWEN  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_ERASE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_CMD,
    SHIFT_WR,
    SHIFT_RD,
    CS_GAP,
    POLL,
    FINISH
  } state_e;

  // Opcode bits sent on DI right after the start bit.
  localparam logic [1:0] OPC_EWEN  = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_ERASE = 2'b11;

  function automatic logic [1:0] opcode_of(input op_e o);
    logic [1:0] opc;
    opc = OPC_EWEN;
    case (o)
      OP_EWEN:  opc = OPC_EWEN;
      OP_WRITE: opc = OPC_WRITE;
      OP_READ:  opc = OPC_READ;
      OP_ERASE: opc = OPC_ERASE;
      default:  opc = OPC_EWEN;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/mw_sk_gen.sv
// ---------------------------------------------------------------------------
// mw_sk_gen
// Bit-slot timer for the Microwire SK clock. While en is high it counts
// 2*DIV clk cycles per slot and flags the cycle before SK should rise
// (rise) and the last cycle of the slot (fall). Dropping en rewinds the
// slot so the next slot starts with a full low phase.
//
// Ports:
//   clk   in  sole clock
//   rst   in  synchronous active-high reset
//   en    in  slot timer running
//   rise  out strobe: SK goes high on the next edge
//   fall  out strobe: SK goes low / slot ends on the next edge
// ---------------------------------------------------------------------------
module mw_sk_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int PER = 2 * DIV;
  localparam int CW  = $clog2(PER);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop in the
    // design samples pre-edge values, regardless of block evaluation order.
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == CW'(PER - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise = en && (cnt == CW'(DIV - 1));
  assign fall = en && (cnt == CW'(PER - 1));

endmodule

// File: rtl/microwire_seq_ctrl.sv
// ---------------------------------------------------------------------------
// microwire_seq_ctrl
// Host-to-Microwire sequencer for 93Cxx-style serial EEPROMs. One accepted
// request runs a complete frame: start bit, opcode, address, then write
// data or read data as the operation needs, a chip-select gap plus
// ready/busy poll for programming operations, and a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, op         host request (taken when req & ready) and operation
//   addr, wdata     word address / write data, captured at accept
//   ready           high only while idle
//   done, err       end-of-transaction pulse; err=1 flags a poll timeout
//   rdata           last READ result, held until the next READ completes
//   cs, sk, di      serial chip-select, clock and data to the EEPROM
//   do_i            serial data from the EEPROM
// ---------------------------------------------------------------------------
module microwire_seq_ctrl
  import microwire_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int DIV     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sk,
  output logic              di,
  input  logic              do_i
);

  localparam int CMD_W   = 3 + ADDR_W;
  localparam int SR_W    = CMD_W + DATA_W;
  localparam int CNT_MAX = (TIMEOUT > SR_W) ? TIMEOUT : SR_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // EWEN carries a fixed "11 then zeros" address field.
  localparam logic [ADDR_W-1:0] EWEN_ADDR = ADDR_W'(2'b11) << (ADDR_W - 2);

  state_e            state;
  op_e               cur_op;
  logic [SR_W-1:0]   sr;      // outgoing bits, next bit to send in the MSB
  logic [DATA_W-1:0] rd_sr;
  logic [CNT_W-1:0]  cnt;     // slot index in shift states, cycles in POLL

  op_e               req_op;
  logic [CMD_W-1:0]  frame;
  logic [DATA_W-1:0] rd_next;
  logic              sk_en;
  logic              rise;
  logic              fall;
  logic              last_slot;

  assign req_op  = op_e'(op);
  assign frame   = {1'b1, opcode_of(req_op), (req_op == OP_EWEN) ? EWEN_ADDR : addr};
  assign rd_next = {rd_sr[DATA_W-2:0], do_i};

  // The slot timer also paces the chip-select gap (one slot long).
  assign sk_en = (state == SHIFT_CMD) || (state == SHIFT_WR) ||
                 (state == SHIFT_RD)  || (state == CS_GAP);

  assign last_slot = (state == SHIFT_CMD) ? (cnt == CNT_W'(CMD_W - 1))
                                          : (cnt == CNT_W'(DATA_W - 1));

  mw_sk_gen #(
    .DIV (DIV)
  ) u_sk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sk_en),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur_op <= OP_EWEN;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      cs     <= 1'b0;
      sk     <= 1'b0;
      di     <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
      // NOTE: the shift registers hold no control state, but they are reset
      // as well so everything observable after rst is deterministic.
      sr     <= '0;
      rd_sr  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state  <= SHIFT_CMD;
            cur_op <= req_op;
            ready  <= 1'b0;
            cs     <= 1'b1;
            sk     <= 1'b0;
            di     <= frame[CMD_W-1];
            sr     <= {frame[CMD_W-2:0], wdata, 1'b0};
            cnt    <= '0;
          end
        end

        SHIFT_CMD, SHIFT_WR, SHIFT_RD: begin
          if (rise) begin
            sk <= 1'b1;
            if (state == SHIFT_RD) begin
              rd_sr <= rd_next;
              if (last_slot) begin
                rdata <= rd_next;
              end
            end
          end
          if (fall) begin
            sk <= 1'b0;
            if (!last_slot) begin
              cnt <= cnt + 1'b1;
              di  <= (state == SHIFT_RD) ? 1'b0 : sr[SR_W-1];
              sr  <= sr << 1;
            end else begin
              cnt <= '0;
              if (state == SHIFT_CMD) begin
                case (cur_op)
                  OP_WRITE: begin
                    state <= SHIFT_WR;
                    di    <= sr[SR_W-1];
                    sr    <= sr << 1;
                  end
                  OP_READ: begin
                    state <= SHIFT_RD;
                    di    <= 1'b0;
                  end
                  OP_EWEN: begin
                    state <= FINISH;
                    cs    <= 1'b0;
                    di    <= 1'b0;
                    done  <= 1'b1;
                  end
                  default: begin
                    state <= CS_GAP;
                    cs    <= 1'b0;
                    di    <= 1'b0;
                  end
                endcase
              end else if (state == SHIFT_WR) begin
                state <= CS_GAP;
                cs    <= 1'b0;
                di    <= 1'b0;
              end else begin
                state <= FINISH;
                cs    <= 1'b0;
                di    <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        // Raising cs again after the gap makes the EEPROM present its
        // ready/busy status on DO.
        CS_GAP: begin
          if (fall) begin
            state <= POLL;
            cs    <= 1'b1;
          end
        end

        POLL: begin
          if (do_i) begin
            state <= FINISH;
            cs    <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= FINISH;
            cs    <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          ready <= 1'b1;
          cnt   <= '0;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/microwire_seq_ctrl.md
MICROWIRE_SEQ_CTRL -- requirements
Module: microwire_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, EEPROM address width in bits.
REQ-002 Parameter DATA_W, default 16, EEPROM word width in bits.
REQ-003 Parameter DIV, default 2, clk cycles per SK half-period (min 1).
REQ-004 Parameter TIMEOUT, default 4096, max clk cycles of ready-poll before error.
REQ-005 clk  in  1  sole clock; all state changes on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  1  host request; accepted on the cycle where req & ready.
REQ-008 op  in  2  operation: 0=EWEN, 1=WRITE, 2=READ, 3=ERASE.
REQ-009 addr  in  ADDR_W  word address, sampled at accept.
REQ-010 wdata  in  DATA_W  write data, sampled at accept.
REQ-011 ready  out  1  high only in IDLE.
REQ-012 done  out  1  one-cycle pulse at end of every transaction.
REQ-013 err  out  1  valid with done: 1 = poll timeout.
REQ-014 rdata  out  DATA_W  READ result, held stable from done until the next READ completes.
REQ-015 cs, sk, di  out  1 each  serial chip-select, clock and data to the EEPROM.
REQ-016 do_i  in  1  serial data from the EEPROM.

Function
REQ-017 The block SHALL implement the states IDLE, SHIFT_CMD, SHIFT_WR, SHIFT_RD, CS_GAP, POLL and FINISH.
REQ-018 Bit slot: DI set at slot start with SK low for DIV cycles, then SK high for DIV cycles; DO sampled on the cycle SK goes high.
REQ-019 Command frame: start bit 1, 2 opcode bits (EWEN=00, WRITE=01, READ=10, ERASE=11), then ADDR_W address bits, all MSB first.
REQ-020 EWEN address field SHALL be binary 11 followed by zeros, ignoring addr.
REQ-021 On accept: cs=1, enter SHIFT_CMD, latch op/addr/wdata; requests while not ready are ignored.
REQ-022 After SHIFT_CMD: WRITE goes to SHIFT_WR (DATA_W bits of wdata MSB first); READ goes to SHIFT_RD; EWEN goes to FINISH; ERASE goes to CS_GAP.
REQ-023 SHIFT_RD SHALL shift in DATA_W bits MSB first with di=0 and load rdata at the last sample.
REQ-024 CS_GAP: cs=0, sk=0 for 2*DIV cycles, then cs=1 and enter POLL.
REQ-025 POLL: sample do_i each cycle; do_i=1 goes to FINISH with err=0; TIMEOUT cycles without do_i=1 goes to FINISH with err=1.
REQ-026 FINISH: cs=0, sk=0, di=0 for one cycle, done=1, then IDLE (ready=1 next cycle).
REQ-027 READ latency: done SHALL assert exactly (3+ADDR_W+DATA_W)*2*DIV+1 cycles after accept (101 for the defaults).
REQ-028 EWEN latency SHALL be (3+ADDR_W)*2*DIV+1 cycles (37 for the defaults).
REQ-029 A back-to-back req held high SHALL be accepted on the cycle after done at the earliest.
REQ-030 Bit and poll counters SHALL be sized to cover max(DATA_W, TIMEOUT) with no wrap inside a transaction.

Reset
REQ-031 Reset values: state=IDLE, ready=1, cs=0, sk=0, di=0, done=0, err=0, rdata=0, all counters 0.
REQ-032 rst asserted mid-transaction SHALL abort it on the next edge: no done pulse, and serial outputs take their reset values.

Structure
REQ-033 A shared package SHALL hold the op enum, the state enum and the 2-bit opcode constants.
REQ-034 One sub-module, mw_sk_gen (DIV-counted SK generator giving rise/fall strobes), is natural; everything else stays flat.

Verification
REQ-035 Reset mid-READ at cycle 40 -> cs=0, sk=0 and ready=1 the cycle after; no done pulse.
REQ-036 EWEN -> di frame 1,00,110000; done at cycle 37, err=0.
REQ-037 READ addr=0x05 with the model driving 0xA5C3 -> di frame 1,10,000101; rdata=0xA5C3 with done at cycle 101.
REQ-038 WRITE addr=0x3F, wdata=0x1234 with the model asserting do_i 50 cycles into POLL -> 16 data bits 0x1234 on di, cs low for 4 cycles before POLL, done with err=0.
REQ-039 ERASE with do_i stuck at 0 -> done exactly TIMEOUT cycles after POLL entry, err=1.
REQ-040 req held high across two READs -> second accept exactly one cycle after the first done; req pulses while busy are ignored.
